pc_fetch_queue: RTL and testbench
=================================

PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and instruction-memory address width; minimum 8.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset; bits [1:0] are 0.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port imem_addr_o  output  ADDR_W  fetch address to the combinational instruction memory.
REQ-007 SHALL have port imem_instr_i  input  32  instruction word at imem_addr_o, same cycle.
REQ-008 SHALL have port halt_i  input  1  suppresses enqueue while high.
REQ-009 SHALL have port redirect_i  input  1  branch, jump or jr taken: flush and refetch.
REQ-010 SHALL have port redirect_pc_i  input  ADDR_W  redirect target.
REQ-011 SHALL have port instr_valid_o  output  1  queue head valid.
REQ-012 SHALL have port instr_ready_i  input  1  consumer accepts head.
REQ-013 SHALL have port instr_o  output  32  head instruction.
REQ-014 SHALL have port instr_pc_o  output  ADDR_W  head instruction address.
REQ-015 SHALL have port pc_plus4_o  output  ADDR_W  instr_pc_o + 4, modulo 2^ADDR_W.
REQ-016 SHALL have port count_o  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-017 SHALL drive imem_addr_o from internal fetch PC (fpc) at all times.
REQ-018 SHALL push {fpc, imem_instr_i} and advance fpc by 4 (wrapping modulo 2^ADDR_W) when count_o < DEPTH, halt_i = 0, redirect_i = 0.
REQ-019 SHALL pop the head when instr_valid_o and instr_ready_i are both 1 and redirect_i = 0.
REQ-020 SHALL block push when count_o = DEPTH, even if a pop occurs that cycle.
REQ-021 SHALL, on simultaneous push and pop, leave count_o unchanged and advance both pointers.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL drive instr_valid_o = (count_o != 0); instr_o, instr_pc_o and pc_plus4_o hold the head entry.
REQ-024 SHALL hold all outputs and the head steady while instr_valid_o = 1 and instr_ready_i = 0.
REQ-025 SHALL, when redirect_i = 1, take priority over push, pop and halt_i: clear the queue (count_o = 0 next cycle) and load fpc with redirect_pc_i, bits [1:0] forced to 0.
REQ-026 SHALL discard any handshake in a redirect cycle; the head is not consumed.
REQ-027 SHALL present the redirect-target instruction two cycles after the redirect (redirect in cycle N: push in N+1, instr_valid_o = 1 in N+2), provided halt_i = 0 in N+1.
REQ-028 SHALL keep fpc and queue contents unchanged while halt_i = 1 (pops still allowed).

Reset
REQ-029 SHALL, when rst_i = 1 at a clock edge, set fpc = RESET_PC, pointers = 0 and count_o = 0, giving instr_valid_o = 0 the next cycle.
REQ-030 SHALL let rst_i override redirect_i, halt_i and handshakes, including mid-fill or mid-redirect.
REQ-031 SHALL set imem_addr_o = RESET_PC in the first cycle after reset.

Configuration
REQ-032 SHALL, with macro FETCH_JUMP_PREDECODE_EN defined, predecode the pushed word.
- If imem_instr_i[31:26] = 6'b000010 (j), the word is still enqueued.
- fpc loads {(fpc+4)[ADDR_W-1:28], imem_instr_i[25:0], 2'b00} instead of fpc+4; upper slice omitted when ADDR_W <= 28, result truncated to ADDR_W.
- The queue is not flushed.
REQ-033 SHALL, without FETCH_JUMP_PREDECODE_EN, treat j like any other word (fpc+4); jumps then require redirect_i.

Verification
REQ-034 SHALL cover reset then fill: RESET_PC=0, ready=0, memory word = address -> after 4 cycles count_o=4, imem_addr_o=0x10, head instr_pc_o=0, pc_plus4_o=4.
REQ-035 SHALL cover full with simultaneous pop: count_o=4, ready=1 for one cycle -> count_o=3, head instr_pc_o=4, no push that cycle.
REQ-036 SHALL cover streaming: ready=1 continuously from reset -> one instruction per cycle, PCs 0,4,8,... from cycle 2, count_o settles at 1.
REQ-037 SHALL cover redirect: redirect_i=1, redirect_pc_i=0x43 with queue holding 3 entries -> next cycle count_o=0, imem_addr_o=0x40; two cycles after redirect, instr_pc_o=0x40.
REQ-038 SHALL cover halt and reset mid-operation: halt_i=1 for 3 cycles -> fpc frozen; rst_i during redirect -> fpc=RESET_PC, count_o=0.
REQ-039 SHALL cover FETCH_JUMP_PREDECODE_EN defined: word 0x08000010 at 0x8 -> next imem_addr_o=0x40, j entry still enqueued with instr_pc_o=0x8.

Source files
------------

// File: rtl/pc_fetch_queue.sv
// Instruction prefetch queue: fetches sequentially from a combinational imem and buffers {pc, instr}.
// Optional jump predecode enabled by defining FETCH_JUMP_PREDECODE_EN.
module pc_fetch_queue #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic [ADDR_W-1:0]            imem_addr_o,
    input  logic [31:0]                  imem_instr_i,
    input  logic                         halt_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    output logic                         instr_valid_o,
    input  logic                         instr_ready_i,
    output logic [31:0]                  instr_o,
    output logic [ADDR_W-1:0]            instr_pc_o,
    output logic [ADDR_W-1:0]            pc_plus4_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];

    logic              push, pop;
    logic [ADDR_W-1:0] fpc_plus4, fpc_seq;

    assign fpc_plus4 = fpc_q + ADDR_W'(4);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic [27:0]       jt28;
    logic [ADDR_W-1:0] jtarget;
    logic              is_j;

    assign jt28 = {imem_instr_i[25:0], 2'b00};
    assign is_j = (imem_instr_i[31:26] == 6'b000010);

    generate
        if (ADDR_W > 28) begin : g_jwide
            assign jtarget = {fpc_plus4[ADDR_W-1:28], jt28};
        end else begin : g_jnarrow
            assign jtarget = jt28[ADDR_W-1:0];
        end
    endgenerate

    assign fpc_seq = is_j ? jtarget : fpc_plus4;
`else
    assign fpc_seq = fpc_plus4;
`endif

    // Full blocks push using the pre-pop count, so a pop never frees a slot in the same cycle.
    assign push = (count_q != CW'(DEPTH)) && !halt_i && !redirect_i;
    assign pop  = (count_q != '0) && instr_ready_i && !redirect_i;

    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            fpc_d    = redirect_pc_i & ~ADDR_W'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fpc_d    = fpc_seq;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr_i;
        end
    end

    assign imem_addr_o   = fpc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_mem_q[rd_ptr_q];
    assign instr_pc_o    = pc_mem_q[rd_ptr_q];
    assign pc_plus4_o    = pc_mem_q[rd_ptr_q] + ADDR_W'(4);
    assign count_o       = count_q;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: directed vector table, reference-model scoreboard, random traffic.
module tb_pc_fetch_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RPC    = 32'h0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        halt_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_plus4_o;
    logic [2:0]  count_o;
    logic        jmode = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i(clk), .rst_i(rst_i), .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
        .halt_i(halt_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .pc_plus4_o(pc_plus4_o), .count_o(count_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic jm);
        return (jm && a == 32'h8) ? 32'h0800_0010 : a;
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o, jmode);

    // Reference model: fetch PC and a queue of {pc, instr} entries (the scoreboard)
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        sb[$];
    logic [31:0] m_fpc;

    task automatic model_update();
        logic do_push, do_pop;
        logic [31:0] w;
        if (rst_i) begin
            m_fpc = RPC;
            sb.delete();
        end else if (redirect_i) begin
            m_fpc = redirect_pc_i & 32'hFFFF_FFFC;
            sb.delete();
        end else begin
            do_pop  = (sb.size() != 0) && instr_ready_i;
            do_push = (sb.size() < DEPTH) && !halt_i;
            w = mem_word(m_fpc, jmode);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back('{pc: m_fpc, instr: w});
`ifdef FETCH_JUMP_PREDECODE_EN
                if (w[31:26] == 6'b000010)
                    m_fpc = {m_fpc[31:28] + ((m_fpc[27:0] >= 28'hFFFFFFC) ? 4'd1 : 4'd0), w[25:0], 2'b00};
                else
                    m_fpc = m_fpc + 32'd4;
`else
                m_fpc = m_fpc + 32'd4;
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        chk("sb_count", 32'(count_o), 32'(sb.size()));
        chk("sb_addr", imem_addr_o, m_fpc);
        chk("sb_valid", 32'(instr_valid_o), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("sb_head_pc", instr_pc_o, sb[0].pc);
            chk("sb_head_instr", instr_o, sb[0].instr);
            chk("sb_pc_plus4", pc_plus4_o, sb[0].pc + 32'd4);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        sb_check();
    endtask

    typedef struct {
        logic rst; logic halt; logic redir; logic [31:0] rpc; logic ready;
        int cnt; logic [31:0] addr; logic [31:0] hpc;
    } vec_t;
    vec_t vq[$];

    initial begin
        // Directed expectations derived by hand; hpc ignored when cnt == 0
        vq.push_back('{1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'h4,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 2, 32'h8,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 3, 32'hC,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 4, 32'h10,       32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 4, 32'h10,       32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        1, 3, 32'h10,       32'h4});
        vq.push_back('{0, 0, 1, 32'h43,       0, 0, 32'h40,       32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'h44,       32'h40});
        vq.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h44,       32'h40});
        vq.push_back('{0, 1, 0, 32'h0,        1, 0, 32'h44,       32'h0});
        vq.push_back('{0, 1, 0, 32'h0,        1, 0, 32'h44,       32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'h48,       32'h44});
        vq.push_back('{0, 0, 0, 32'h0,        0, 2, 32'h4C,       32'h44});
        vq.push_back('{1, 0, 1, 32'h100,      1, 0, 32'h0,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        1, 1, 32'h4,        32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        1, 1, 32'h8,        32'h4});
        vq.push_back('{0, 0, 0, 32'h0,        1, 1, 32'hC,        32'h8});
        vq.push_back('{0, 0, 1, 32'h20,       1, 0, 32'h20,       32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        1, 1, 32'h24,       32'h20});
        vq.push_back('{0, 0, 1, 32'hFFFFFFF9, 0, 0, 32'hFFFFFFF8, 32'h0});
        vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 32'hFFFFFFF8});
        vq.push_back('{0, 0, 0, 32'h0,        0, 2, 32'h0,        32'hFFFFFFF8});
        vq.push_back('{0, 0, 0, 32'h0,        1, 2, 32'h4,        32'hFFFFFFFC});

        foreach (vq[i]) begin
            rst_i = vq[i].rst; halt_i = vq[i].halt; redirect_i = vq[i].redir;
            redirect_pc_i = vq[i].rpc; instr_ready_i = vq[i].ready;
            cycle();
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vq[i].cnt));
            chk($sformatf("vec%0d_addr", i), imem_addr_o, vq[i].addr);
            if (vq[i].cnt != 0) chk($sformatf("vec%0d_head_pc", i), instr_pc_o, vq[i].hpc);
        end
        chk("wrap_pc_plus4", pc_plus4_o, 32'h0);

        // Stalled head must hold steady while valid and not ready
        rst_i = 0; halt_i = 0; redirect_i = 0; instr_ready_i = 0;
        cycle();
        begin
            logic [31:0] hold_pc, hold_instr;
            hold_pc = instr_pc_o; hold_instr = instr_o;
            repeat (3) cycle();
            chk("stall_head_pc", instr_pc_o, 32'hFFFFFFFC);
            chk("stall_head_instr", instr_o, hold_instr);
            chk("stall_pc_hold", instr_pc_o, hold_pc);
        end

        // Random traffic, checked only by the scoreboard
        for (int unsigned n = 0; n < 400; n++) begin
            rst_i = ($urandom_range(63) == 0);
            redirect_i = ($urandom_range(15) == 0);
            redirect_pc_i = $urandom & 32'h0000_FFFF;
            halt_i = ($urandom_range(3) == 0);
            instr_ready_i = $urandom_range(1);
            cycle();
        end

`ifdef FETCH_JUMP_PREDECODE_EN
        rst_i = 1; halt_i = 0; redirect_i = 0; instr_ready_i = 0; jmode = 1;
        cycle();
        rst_i = 0;
        repeat (3) cycle();
        chk("j_target_addr", imem_addr_o, 32'h40);
        chk("j_count", 32'(count_o), 32'd3);
        instr_ready_i = 1;
        repeat (2) cycle();
        chk("j_entry_pc", instr_pc_o, 32'h8);
        chk("j_entry_instr", instr_o, 32'h0800_0010);
        jmode = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
